// File: rtl/rti_return_handler_pkg.sv
// Shared control definitions for the RTI return handler: state encoding,
// injected opcodes and per-state decode helpers.
package rti_return_handler_pkg;

  localparam int FLAG_W       = 3;
  localparam int PC_W         = 32;
  localparam int INSTR_W      = 16;
  localparam int WAIT_MAX_DEF = 8;

  localparam logic [INSTR_W-1:0] POP_FLAGS_INSTR = 16'hF600;
  localparam logic [INSTR_W-1:0] POP_PC_INSTR    = 16'hF680;
  localparam logic [INSTR_W-1:0] BUBBLE_INSTR    = 16'h07F8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DEFER     = 3'd1,
    S_INJ_FLAGS = 3'd2,
    S_INJ_PC    = 3'd3,
    S_WAIT      = 3'd4,
    S_REDIRECT  = 3'd5
  } rti_state_e;

  // Opcode presented to decode while the sequencer owns the injection slot.
  function automatic logic [INSTR_W-1:0] injected_instr(input rti_state_e s);
    logic [INSTR_W-1:0] instr;
    instr = '0;
    case (s)
      S_INJ_FLAGS: instr = POP_FLAGS_INSTR;
      S_INJ_PC:    instr = POP_PC_INSTR;
      S_WAIT:      instr = BUBBLE_INSTR;
      default:     instr = '0;
    endcase
    return instr;
  endfunction

  function automatic logic stalls_fetch(input rti_state_e s);
    return (s == S_DEFER) || (s == S_INJ_FLAGS) || (s == S_INJ_PC) || (s == S_WAIT);
  endfunction

  function automatic logic overrides_decode(input rti_state_e s);
    return (s == S_INJ_FLAGS) || (s == S_INJ_PC) || (s == S_WAIT);
  endfunction

endpackage

// File: rtl/rti_return_handler_if.sv
// Pipeline-side bundle between fetch/decode/memory and the RTI return handler.
interface rti_return_handler_if;
  import rti_return_handler_pkg::*;

  logic               rtiDetected;
  logic               interruptBusy;
  logic               memPopValid;
  logic [PC_W-1:0]    memPopData;

  logic               rtiStallFetch;
  logic               rtiRaisedInstruction;
  logic [INSTR_W-1:0] rtiInstruction;
  logic               rtiRaisedPC;
  logic [PC_W-1:0]    rtiPC;
  logic               rtiRestoreFlags;
  logic [FLAG_W-1:0]  rtiFlags;
  logic               rtiError;

  // Pipeline side: raises RTI, reports pops, consumes redirect/injection.
  modport master (
    output rtiDetected, interruptBusy, memPopValid, memPopData,
    input  rtiStallFetch, rtiRaisedInstruction, rtiInstruction,
           rtiRaisedPC, rtiPC, rtiRestoreFlags, rtiFlags, rtiError
  );

  // Handler side.
  modport slave (
    input  rtiDetected, interruptBusy, memPopValid, memPopData,
    output rtiStallFetch, rtiRaisedInstruction, rtiInstruction,
           rtiRaisedPC, rtiPC, rtiRestoreFlags, rtiFlags, rtiError
  );

endinterface

// File: rtl/rti_return_handler.sv
// RTI return sequencer: stalls fetch, injects flag/PC stack pops, collects the
// popped words and issues a one-cycle fetch redirect plus CCR restore.
module rti_return_handler
  import rti_return_handler_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  rti_return_handler_if.slave     bus
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  rti_state_e         state_q, state_d;
  logic [1:0]         pop_cnt_q, pop_cnt_d;
  logic [WC_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               error_q, error_d;
  logic               stall_q, stall_d;
  logic               raised_q, raised_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               raised_pc_q, raised_pc_d;
  logic               restore_q, restore_d;
  logic               pop_accept;

  // Pops are only meaningful once the flag pop has been issued to decode.
  assign pop_accept = bus.memPopValid && (pop_cnt_q != 2'd2) &&
                      ((state_q == S_INJ_PC) || (state_q == S_WAIT));

  always_comb begin
    state_d    = state_q;
    pop_cnt_d  = pop_cnt_q;
    wait_cnt_d = wait_cnt_q;
    flags_d    = flags_q;
    pc_d       = pc_q;
    error_d    = error_q;

    if (pop_accept) begin
      if (pop_cnt_q == 2'd0) begin
        flags_d   = bus.memPopData[FLAG_W-1:0];
        pop_cnt_d = 2'd1;
      end else begin
        pc_d      = bus.memPopData;
        pop_cnt_d = 2'd2;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rtiDetected) begin
          state_d = bus.interruptBusy ? S_DEFER : S_INJ_FLAGS;
        end
      end
      S_DEFER: begin
        if (!bus.interruptBusy) state_d = S_INJ_FLAGS;
      end
      S_INJ_FLAGS: state_d = S_INJ_PC;
      S_INJ_PC:    state_d = S_WAIT;
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // A completing pop on the watchdog's last cycle still wins.
        if (pop_cnt_d == 2'd2) begin
          state_d = S_REDIRECT;
        end else if (wait_cnt_d == WC_W'(WAIT_MAX)) begin
          state_d    = S_IDLE;
          error_d    = 1'b1;
          pop_cnt_d  = 2'd0;
          wait_cnt_d = '0;
        end
      end
      S_REDIRECT: begin
        state_d    = S_IDLE;
        pop_cnt_d  = 2'd0;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = S_IDLE;
        pop_cnt_d  = 2'd0;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register on the same edge.
  always_comb begin
    stall_d     = stalls_fetch(state_d);
    raised_d    = overrides_decode(state_d);
    instr_d     = injected_instr(state_d);
    raised_pc_d = (state_d == S_REDIRECT);
    restore_d   = (state_d == S_REDIRECT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pop_cnt_q   <= 2'd0;
      wait_cnt_q  <= '0;
      flags_q     <= '0;
      pc_q        <= '0;
      error_q     <= 1'b0;
      stall_q     <= 1'b0;
      raised_q    <= 1'b0;
      instr_q     <= '0;
      raised_pc_q <= 1'b0;
      restore_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pop_cnt_q   <= pop_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      flags_q     <= flags_d;
      pc_q        <= pc_d;
      error_q     <= error_d;
      stall_q     <= stall_d;
      raised_q    <= raised_d;
      instr_q     <= instr_d;
      raised_pc_q <= raised_pc_d;
      restore_q   <= restore_d;
    end
  end

  assign bus.rtiStallFetch        = stall_q;
  assign bus.rtiRaisedInstruction = raised_q;
  assign bus.rtiInstruction       = instr_q;
  assign bus.rtiRaisedPC          = raised_pc_q;
  assign bus.rtiPC                = pc_q;
  assign bus.rtiRestoreFlags      = restore_q;
  assign bus.rtiFlags             = flags_q;
  assign bus.rtiError             = error_q;

endmodule
